// File: rtl/seg7_control_if.sv
// seg7_control_if: segment patterns in, multiplexed anode/cathode lines out
interface seg7_control_if;
    logic [7:0] in3;
    logic [7:0] in2;
    logic [7:0] in1;
    logic [7:0] in0;
    logic [3:0] anodo;
    logic [7:0] catodo;
    modport master (output in3, in2, in1, in0, input anodo, catodo);
    modport slave (input in3, in2, in1, in0, output anodo, catodo);
endinterface

// File: rtl/seg7_control.sv
// seg7_control: 4-digit time-multiplexed 7-segment driver; define SEG7_CONTROL_BLANK_EN to blank the last clock of each slot
module seg7_control #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    seg7_control_if.slave bus
);
    logic [CNT_W-1:0] cnt;
    logic [1:0] sel;
    logic last;
    logic [7:0] pat;
    logic [3:0] an_nxt;
    logic [7:0] cat_nxt;
    assign last = cnt == CNT_W'(REFRESH_DIV - 1);
    always_comb begin
        pat = sel == 2'd0 ? bus.in0 : sel == 2'd1 ? bus.in1 : sel == 2'd2 ? bus.in2 : bus.in3;
`ifdef SEG7_CONTROL_BLANK_EN
        an_nxt = last ? 4'b1111 : ~(4'b0001 << sel);
        cat_nxt = last ? 8'hFF : pat;
`else
        an_nxt = ~(4'b0001 << sel);
        cat_nxt = pat;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sel <= 2'd0;
            bus.anodo <= 4'b1111;
            bus.catodo <= 8'hFF;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            sel <= last ? sel + 2'd1 : sel;
            bus.anodo <= an_nxt;
            bus.catodo <= cat_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_control.sv
// tb_seg7_control: scoreboard bench for seg7_control with REFRESH_DIV=4
module tb_seg7_control;
    localparam int R = 4;
`ifdef SEG7_CONTROL_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] cat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int m_cnt = 0;
    logic [1:0] m_sel = 2'd0;
    exp_t sb[$];
    seg7_control_if bus ();
    seg7_control #(.REFRESH_DIV(R), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #10 clk = ~clk;

    function automatic logic [7:0] cur_in(input logic [1:0] s);
        return s == 2'd0 ? bus.in0 : s == 2'd1 ? bus.in1 : s == 2'd2 ? bus.in2 : bus.in3;
    endfunction

    task automatic step();
        exp_t e;
        exp_t g;
        e.an = (BLANK && m_cnt == R - 1) ? 4'b1111 : ~(4'b0001 << m_sel);
        e.cat = (BLANK && m_cnt == R - 1) ? 8'hFF : cur_in(m_sel);
        sb.push_back(e);
        m_sel = (m_cnt == R - 1) ? m_sel + 2'd1 : m_sel;
        m_cnt = (m_cnt == R - 1) ? 0 : m_cnt + 1;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        vectors++;
        if (bus.anodo !== g.an) begin
            miscompares++;
            $display("FAIL step_anodo t=%0t got %b expected %b", $time, bus.anodo, g.an);
        end
        vectors++;
        if (bus.catodo !== g.cat) begin
            miscompares++;
            $display("FAIL step_catodo t=%0t got %h expected %h", $time, bus.catodo, g.cat);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (bus.anodo !== 4'b1111 || bus.catodo !== 8'hFF) begin
            miscompares++;
            $display("FAIL %s got %b/%h expected 1111/ff", name, bus.anodo, bus.catodo);
        end
    endtask

    task automatic release_rst();
        rst = 1'b0;
        m_cnt = 0;
        m_sel = 2'd0;
    endtask

    task automatic test_reset();
        bus.in0 = 8'hC0;
        bus.in1 = 8'hF9;
        bus.in2 = 8'hA4;
        bus.in3 = 8'hB0;
        repeat (2) @(posedge clk);
        #6;
        rst = 1'b1;
        #1;
        check_idle("reset_async");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_idle("reset_hold");
        end
    endtask

    task automatic test_scan();
        release_rst();
        for (int i = 0; i < 12 * R; i++) step();
    endtask

    task automatic test_live_update();
        for (int i = 0; i < 4 * R && !(m_sel == 2'd1 && m_cnt == 1); i++) step();
        bus.in1 = 8'h99;
        step();
        vectors++;
        if (bus.anodo !== 4'b1101 || bus.catodo !== 8'h99) begin
            miscompares++;
            $display("FAIL live_update got %b/%h expected 1101/99", bus.anodo, bus.catodo);
        end
        for (int i = 0; i < 2 * R; i++) step();
    endtask

    task automatic test_onehot();
        for (int i = 0; i < 200; i++) begin
            bus.in0 = 8'($urandom);
            bus.in1 = 8'($urandom);
            bus.in2 = 8'($urandom);
            bus.in3 = 8'($urandom);
            step();
            vectors++;
            if (!($countones(~bus.anodo) == 1 || (BLANK && bus.anodo == 4'b1111))) begin
                miscompares++;
                $display("FAIL onehot got %b expected exactly one zero", bus.anodo);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4 * R && !(m_sel == 2'd2 && m_cnt == 2); i++) step();
        #5;
        rst = 1'b1;
        #1;
        check_idle("midreset_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_idle("midreset_hold");
        end
        release_rst();
        step();
        vectors++;
        if (bus.anodo !== 4'b1110 || bus.catodo !== bus.in0) begin
            miscompares++;
            $display("FAIL midreset_restart got %b/%h expected 1110/%h", bus.anodo, bus.catodo, bus.in0);
        end
        for (int i = 0; i < 4 * R; i++) step();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_live_update();
        test_onehot();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
